// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register, branch condition resolver and
// taken-branch counter sitting behind the saturating add/sub stage.
module flag_branch_unit #(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_N,
    input  logic             alu_Z,
    input  logic             alu_V,
    input  logic [2:0]       flag_wen,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic             cnt_clr,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             br_done,
    output logic             br_taken,
    output logic             br_stall,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [2:0]       cond_q, cond_d;
    logic [2:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       we;
    logic             collide;
    logic             stall_c;

    // f is {N,Z,V}
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic r;
        r = 1'b0;
        unique case (c)
            3'b000: r = ~f[1];
            3'b001: r = f[1];
            3'b010: r = ~f[1] & ~f[2];
            3'b011: r = f[2];
            3'b100: r = f[1] | (~f[1] & ~f[2]);
            3'b101: r = f[2] | f[1];
            3'b110: r = f[0];
            3'b111: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        we      = flag_wen & {3{~stall & ~flush}};
        flags_d = (we & {alu_N, alu_Z, alu_V}) | (~we & flags_q);
        collide = (BYPASS == 1'b0) && (we != 3'b000);

        state_d = state_q;
        cond_d  = cond_q;
        done_d  = 1'b0;
        taken_d = 1'b0;
        stall_c = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        if (collide) begin
                            stall_c = 1'b1;
                            cond_d  = br_cond;
                            state_d = WAIT;
                        end else begin
                            done_d  = 1'b1;
                            taken_d = cond_met(br_cond, flags_d);
                        end
                    end
                end
                WAIT: begin
                    stall_c = 1'b1;
                    done_d  = 1'b1;
                    taken_d = cond_met(cond_q, flags_d);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (done_d && taken_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cond_q  <= 3'b000;
            flags_q <= 3'b000;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign N         = flags_q[2];
    assign Z         = flags_q[1];
    assign V         = flags_q[0];
    assign br_done   = done_q;
    assign br_taken  = taken_q;
    assign br_stall  = stall_c & rst_n;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench: u0 is the stalling variant, u1 the bypass variant
// with a 2-bit counter.
module tb_flag_branch_unit;

    typedef struct packed {
        logic       n;
        logic       z;
        logic       v;
        logic [2:0] wen;
        logic       st;
        logic       fl;
        logic       bv;
        logic [2:0] bc;
        logic       clr;
    } in_t;

    typedef struct packed {
        logic        tk;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    in_t  i0, i1;

    logic        N0, Z0, V0, done0, taken0, stall0;
    logic        N1, Z1, V1, done1, taken1, stall1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    flag_branch_unit #(.BYPASS(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n),
        .alu_N(i0.n), .alu_Z(i0.z), .alu_V(i0.v),
        .flag_wen(i0.wen), .stall(i0.st), .flush(i0.fl),
        .br_valid(i0.bv), .br_cond(i0.bc), .cnt_clr(i0.clr),
        .N(N0), .Z(Z0), .V(V0),
        .br_done(done0), .br_taken(taken0), .br_stall(stall0),
        .taken_cnt(cnt0)
    );

    flag_branch_unit #(.BYPASS(1'b1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .alu_N(i1.n), .alu_Z(i1.z), .alu_V(i1.v),
        .flag_wen(i1.wen), .stall(i1.st), .flush(i1.fl),
        .br_valid(i1.bv), .br_cond(i1.bc), .cnt_clr(i1.clr),
        .N(N1), .Z(Z1), .V(V1),
        .br_done(done1), .br_taken(taken1), .br_stall(stall1),
        .taken_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic n, input logic z, input logic v,
                               input logic [2:0] wen, input logic st,
                               input logic fl, input logic bv,
                               input logic [2:0] bc, input logic clr);
        in_t r;
        r.n = n; r.z = z; r.v = v; r.wen = wen; r.st = st;
        r.fl = fl; r.bv = bv; r.bc = bc; r.clr = clr;
        return r;
    endfunction

    task automatic push(input int which, input logic tk, input int cnt);
        exp_t e;
        e.tk  = tk;
        e.cnt = 16'(cnt);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every br_done pulse must match the oldest expected branch
    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL u0_unexpected_done: got 1 expected 0");
            end else begin
                e = q0.pop_front();
                chk("u0_taken", 32'(taken0), 32'(e.tk));
                chk("u0_cnt", 32'(cnt0), 32'(e.cnt));
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL u1_unexpected_done: got 1 expected 0");
            end else begin
                e = q1.pop_front();
                chk("u1_taken", 32'(taken1), 32'(e.tk));
                chk("u1_cnt", 32'(cnt1), 32'(e.cnt));
            end
        end
    end

    logic [7:0] tk_tab;
    int         cnt_tab[8];

    initial begin
        tk_tab  = 8'b1101_0101;
        cnt_tab = '{1, 1, 2, 2, 3, 3, 4, 5};
        i0 = '0;
        i1 = '0;
        rst_n = 1'b0;

        #12;
        chk("rst_N0", 32'(N0), 0);
        chk("rst_Z0", 32'(Z0), 0);
        chk("rst_V0", 32'(V0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_stall0", 32'(stall0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        tick; rst_n = 1'b1;

        // Flag write and masking on u0
        tick; i0 = mk(1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick; i0 = '0;
        @(negedge clk);
        chk("wr_N", 32'(N0), 1);
        chk("wr_V", 32'(V0), 1);
        tick; i0 = mk(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick; i0 = '0;
        @(negedge clk);
        chk("add_NZV", 32'({N0, Z0, V0}), 0);
        tick; i0 = mk(1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick; i0 = '0;
        @(negedge clk);
        chk("mask_NZV", 32'({N0, Z0, V0}), 32'b010);
        tick; i0 = mk(1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        tick; i0 = '0;
        @(negedge clk);
        chk("stall_hold_NZV", 32'({N0, Z0, V0}), 32'b010);

        // Saturation with a same-cycle OVFL branch, bypassed on u1
        tick; i1 = mk(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
        push(1, 1'b1, 1);
        #1 chk("byp_stall_a", 32'(stall1), 0);
        tick; i1 = '0;
        chk("byp_stall_b", 32'(stall1), 0);
        @(negedge clk);
        chk("byp_V", 32'(V1), 1);
        tick;

        // Colliding EQ branch stalls on u0 and sees the new Z=0
        tick; i0 = mk(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
        push(0, 1'b0, 0);
        #1 chk("col_stall_c1", 32'(stall0), 1);
        tick; i0 = '0;
        #1 chk("col_stall_c2", 32'(stall0), 1);
        tick;
        #1 chk("col_stall_c3", 32'(stall0), 0);
        @(negedge clk);
        chk("col_NZV", 32'({N0, Z0, V0}), 32'b001);

        // Back-to-back branches on u0 with flags N=0 Z=0 V=1
        for (int k = 0; k < 8; k++) begin
            tick; i0 = mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'(k), 1'b0);
            push(0, tk_tab[k], cnt_tab[k]);
            #1 chk("b2b_stall", 32'(stall0), 0);
        end
        tick; i0 = '0;
        tick;

        // Flush while waiting
        tick; i0 = mk(1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
        #1 chk("fl_stall_pre", 32'(stall0), 1);
        tick; i0 = mk(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        #1 chk("fl_stall", 32'(stall0), 0);
        tick; i0 = '0;
        #1 chk("fl_idle", 32'(stall0), 0);
        @(negedge clk);
        chk("fl_NZV", 32'({N0, Z0, V0}), 32'b100);
        chk("fl_cnt", 32'(cnt0), 5);
        chk("fl_done", 32'(done0), 0);

        // Asynchronous reset in the middle of a wait
        tick; i0 = mk(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
        tick; i0 = '0;
        #1 chk("rw_stall_pre", 32'(stall0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_NZV", 32'({N0, Z0, V0}), 0);
        chk("rw_done", 32'(done0), 0);
        chk("rw_stall", 32'(stall0), 0);
        chk("rw_cnt0", 32'(cnt0), 0);
        chk("rw_cnt1", 32'(cnt1), 0);
        tick; rst_n = 1'b1;

        // Saturating 2-bit counter on u1, then clear against an increment
        for (int k = 0; k < 5; k++) begin
            tick; i1 = mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
            push(1, 1'b1, (k < 3) ? k + 1 : 3);
        end
        tick; i1 = mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        push(1, 1'b1, 0);
        tick; i1 = mk(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
        push(1, 1'b1, 1);
        tick; i1 = '0;
        tick;
        tick;
        @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
